// File: rtl/sent_pkg.sv
// Shared definitions for the SENT fast-channel receiver.
// Contents: frame timing constants in ticks, the frame FSM state enum and
// the 4-bit CRC step function (poly x^4+x^3+x^2+1).
package sent_pkg;

  localparam int SYNC_TICKS = 56;
  localparam int NIB_MIN    = 12;
  localparam int NIB_MAX    = 27;
  localparam int PAUSE_MAX  = 768;
  localparam logic [3:0] CRC_SEED = 4'h5;

  typedef enum logic [2:0] {
    ST_HUNT   = 3'd0,
    ST_SYNC   = 3'd1,
    ST_STATUS = 3'd2,
    ST_DATA   = 3'd3,
    ST_CRC    = 3'd4,
    ST_POST   = 3'd5
  } rx_state_e;

  // crc' = LUT[crc] ^ nib, where LUT[i] = (i * x^4) mod poly.
  // The LUT is linear over GF(2), so it is built from the images of the
  // four basis vectors: 1->D, 2->7, 4->E, 8->1.
  function automatic logic [3:0] crc4_step(input logic [3:0] crc,
                                           input logic [3:0] nib);
    logic [3:0] t;
    t = 4'h0;
    if (crc[0]) t = t ^ 4'hD;
    if (crc[1]) t = t ^ 4'h7;
    if (crc[2]) t = t ^ 4'hE;
    if (crc[3]) t = t ^ 4'h1;
    return t ^ nib;
  endfunction

endpackage

// File: rtl/sent_rx_tick_meter.sv
// Measures falling-edge-to-falling-edge periods of the SENT line in ticks.
// Ports:
//   clk_rx_i     receive clock
//   reset_i      asynchronous active-high reset
//   data_pulse_i raw SENT line (asynchronous)
//   fe_o         one-cycle falling-edge pulse
//   period_o     rounded period in ticks, meaningful while fe_o is high
//   sat_o        tick counter sits at its 1023 ceiling
module sent_rx_tick_meter #(
  parameter int TICK_DIV = 4
) (
  input  logic        clk_rx_i,
  input  logic        reset_i,
  input  logic        data_pulse_i,
  output logic        fe_o,
  output logic [10:0] period_o,
  output logic        sat_o
);

  localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [PW-1:0] PRESC_HALF = PW'(TICK_DIV / 2);

  // [0],[1] form the synchronizer, [2] holds the previous synchronized value
  logic [2:0]    sync_q;
  logic [PW-1:0] presc_q, presc_d;
  logic [9:0]    tick_q, tick_d;
  logic          fe;
  logic          round_up;

  assign fe = sync_q[2] & ~sync_q[1];

  always_comb begin
    presc_d = presc_q;
    tick_d  = tick_q;
    if (fe) begin
      presc_d = '0;
      tick_d  = '0;
    end else if (presc_q == PRESC_LAST) begin
      presc_d = '0;
      if (tick_q != 10'h3FF) tick_d = tick_q + 10'd1;
    end else begin
      presc_d = presc_q + PW'(1);
    end
  end

  always_ff @(posedge clk_rx_i or posedge reset_i) begin
    if (reset_i) begin
      sync_q  <= 3'b000;
      presc_q <= '0;
      tick_q  <= '0;
    end else begin
      sync_q  <= {sync_q[1:0], data_pulse_i};
      presc_q <= presc_d;
      tick_q  <= tick_d;
    end
  end

  // A partly elapsed tick counts as a full one once past its midpoint, so an
  // edge landing a cycle early or late still yields the nominal tick count.
  assign round_up = (presc_q >= PRESC_HALF);
  assign period_o = {1'b0, tick_q} + {10'd0, round_up};
  assign fe_o     = fe;
  assign sat_o    = (tick_q == 10'h3FF);

endmodule

// File: rtl/sent_rx_frame_decoder.sv
// SENT fast-channel frame decoder: sync / status / data / CRC recovery.
// Ports:
//   clk_rx, reset      clock, asynchronous active-high reset
//   data_pulse         SENT line
//   frame_valid        one-cycle strobe for each completed frame
//   status_nibble, frame_data, crc_rx, crc_error
//                      contents of the last frame, held until the next one
//   sync_error, nibble_error, timeout
//                      one-cycle error strobes
//   dbg_state          current frame FSM state (rx_state_e encoding)
// Handshake: no back-pressure; frame_valid is a qualifier only, and the
// published fields are stable from frame_valid until the next frame_valid.
module sent_rx_frame_decoder
  import sent_pkg::*;
#(
  parameter int TICK_DIV     = 4,
  parameter int DATA_NIBBLES = 6,
  parameter int SYNC_TOL     = 1
) (
  input  logic        clk_rx,
  input  logic        reset,
  input  logic        data_pulse,
  output logic        frame_valid,
  output logic [3:0]  status_nibble,
  output logic [23:0] frame_data,
  output logic [3:0]  crc_rx,
  output logic        crc_error,
  output logic        sync_error,
  output logic        nibble_error,
  output logic        timeout,
  output logic [2:0]  dbg_state
);

  localparam logic [10:0] SYNC_LO  = 11'(SYNC_TICKS - SYNC_TOL);
  localparam logic [10:0] SYNC_HI  = 11'(SYNC_TICKS + SYNC_TOL);
  localparam logic [10:0] NIB_LO   = 11'(NIB_MIN);
  localparam logic [10:0] NIB_HI   = 11'(NIB_MAX);
  localparam logic [10:0] PAUSE_HI = 11'(PAUSE_MAX);
  localparam logic [2:0]  IDX_LAST = 3'(DATA_NIBBLES - 1);

  logic        fe;
  logic [10:0] period;
  logic        sat;

  sent_rx_tick_meter #(.TICK_DIV(TICK_DIV)) u_meter (
    .clk_rx_i     (clk_rx),
    .reset_i      (reset),
    .data_pulse_i (data_pulse),
    .fe_o         (fe),
    .period_o     (period),
    .sat_o        (sat)
  );

  rx_state_e   state_q, state_d;
  logic        first_q, first_d;      // next SYNC period is the first after HUNT
  logic [2:0]  idx_q, idx_d;
  logic [3:0]  crc_q, crc_d;
  logic [3:0]  stat_q, stat_d;        // status of the frame being received
  logic [23:0] data_q, data_d;        // data of the frame being received
  logic        fv_q, fv_d;
  logic [3:0]  pub_stat_q, pub_stat_d;
  logic [23:0] pub_data_q, pub_data_d;
  logic [3:0]  pub_crc_q, pub_crc_d;
  logic        crc_err_q, crc_err_d;
  logic        sync_err_q, sync_err_d;
  logic        nib_err_q, nib_err_d;
  logic        to_q, to_d;

  logic       nib_ok, sync_ok, pause_ok;
  logic [3:0] nib;

  assign nib_ok   = (period >= NIB_LO) && (period <= NIB_HI);
  assign sync_ok  = (period >= SYNC_LO) && (period <= SYNC_HI);
  assign pause_ok = (period >= NIB_LO) && (period <= PAUSE_HI);
  assign nib      = period[3:0] - 4'd12;

  always_comb begin
    state_d    = state_q;
    first_d    = first_q;
    idx_d      = idx_q;
    crc_d      = crc_q;
    stat_d     = stat_q;
    data_d     = data_q;
    fv_d       = 1'b0;
    pub_stat_d = pub_stat_q;
    pub_data_d = pub_data_q;
    pub_crc_d  = pub_crc_q;
    crc_err_d  = crc_err_q;
    sync_err_d = 1'b0;
    nib_err_d  = 1'b0;
    to_d       = 1'b0;

    // Saturation wins over a coincident edge: the measured period is junk.
    if (state_q != ST_HUNT && sat) begin
      to_d    = 1'b1;
      state_d = ST_HUNT;
    end else if (fe) begin
      unique case (state_q)
        ST_HUNT: begin
          state_d = ST_SYNC;
          first_d = 1'b1;
        end
        ST_SYNC: begin
          first_d = 1'b0;
          if (sync_ok) state_d = ST_STATUS;
          else if (!first_q) sync_err_d = 1'b1;
        end
        ST_STATUS: begin
          if (nib_ok) begin
            stat_d  = nib;
            crc_d   = CRC_SEED;
            data_d  = '0;
            idx_d   = '0;
            state_d = ST_DATA;
          end else begin
            nib_err_d = 1'b1;
            state_d   = ST_SYNC;
          end
        end
        ST_DATA: begin
          if (nib_ok) begin
            for (int i = 0; i < 6; i++) begin
              if (idx_q == 3'(i)) data_d[23-4*i -: 4] = nib;
            end
            crc_d = crc4_step(crc_q, nib);
            if (idx_q == IDX_LAST) state_d = ST_CRC;
            else idx_d = idx_q + 3'd1;
          end else begin
            nib_err_d = 1'b1;
            state_d   = ST_SYNC;
          end
        end
        ST_CRC: begin
          if (nib_ok) begin
            pub_stat_d = stat_q;
            pub_data_d = data_q;
            pub_crc_d  = nib;
            // final augmentation step: feed a zero nibble
            crc_err_d  = (nib != crc4_step(crc_q, 4'h0));
            fv_d       = 1'b1;
            state_d    = ST_POST;
          end else begin
            nib_err_d = 1'b1;
            state_d   = ST_SYNC;
          end
        end
        ST_POST: begin
          // Either the sync of the next frame directly, or a pause first.
          if (sync_ok) state_d = ST_STATUS;
          else begin
            if (!pause_ok) sync_err_d = 1'b1;
            state_d = ST_SYNC;
          end
        end
        default: state_d = ST_HUNT;
      endcase
    end
  end

  always_ff @(posedge clk_rx or posedge reset) begin
    if (reset) begin
      state_q    <= ST_HUNT;
      first_q    <= 1'b0;
      idx_q      <= '0;
      crc_q      <= '0;
      stat_q     <= '0;
      data_q     <= '0;
      fv_q       <= 1'b0;
      pub_stat_q <= '0;
      pub_data_q <= '0;
      pub_crc_q  <= '0;
      crc_err_q  <= 1'b0;
      sync_err_q <= 1'b0;
      nib_err_q  <= 1'b0;
      to_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      first_q    <= first_d;
      idx_q      <= idx_d;
      crc_q      <= crc_d;
      stat_q     <= stat_d;
      data_q     <= data_d;
      fv_q       <= fv_d;
      pub_stat_q <= pub_stat_d;
      pub_data_q <= pub_data_d;
      pub_crc_q  <= pub_crc_d;
      crc_err_q  <= crc_err_d;
      sync_err_q <= sync_err_d;
      nib_err_q  <= nib_err_d;
      to_q       <= to_d;
    end
  end

  assign frame_valid   = fv_q;
  assign status_nibble = pub_stat_q;
  assign frame_data    = pub_data_q;
  assign crc_rx        = pub_crc_q;
  assign crc_error     = crc_err_q;
  assign sync_error    = sync_err_q;
  assign nibble_error  = nib_err_q;
  assign timeout       = to_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_sent_rx_frame_decoder.sv
// Bench for sent_rx_frame_decoder: directed scenarios plus random frames,
// with expected frames derived from a bitwise polynomial-division CRC.
module tb_sent_rx_frame_decoder;
  import sent_pkg::*;

  localparam int TD = 4;
  localparam int NN = 6;
  localparam int W  = 33;   // {crc_err, status[3:0], data[23:0], crc[3:0]}

  logic        clk_rx = 1'b0;
  logic        reset;
  logic        data_pulse;
  logic        frame_valid;
  logic [3:0]  status_nibble;
  logic [23:0] frame_data;
  logic [3:0]  crc_rx;
  logic        crc_error;
  logic        sync_error;
  logic        nibble_error;
  logic        timeout;
  logic [2:0]  dbg_state;

  // ---------------- clock / reset block ----------------
  always #5 clk_rx = ~clk_rx;

  sent_rx_frame_decoder #(.TICK_DIV(TD), .DATA_NIBBLES(NN), .SYNC_TOL(1)) dut (
    .clk_rx        (clk_rx),
    .reset         (reset),
    .data_pulse    (data_pulse),
    .frame_valid   (frame_valid),
    .status_nibble (status_nibble),
    .frame_data    (frame_data),
    .crc_rx        (crc_rx),
    .crc_error     (crc_error),
    .sync_error    (sync_error),
    .nibble_error  (nibble_error),
    .timeout       (timeout),
    .dbg_state     (dbg_state)
  );

  int n_cmp = 0;
  int n_err = 0;

  logic [W-1:0] exp_q[$];
  int cnt_fv, cnt_sync, cnt_nib, cnt_to;
  int exp_fv, exp_sync, exp_nib, exp_to;

  task automatic check_eq(input string tag, input logic [63:0] got,
                          input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference CRC: remainder of the bit string {seed, data nibbles, 0000}
  // divided by x^4+x^3+x^2+1, long division one bit at a time.
  function automatic logic [3:0] ref_crc(input logic [23:0] d);
    logic [3:0] rem;
    logic [3:0] nibs[NN+2];
    logic       fb;
    rem = 4'h0;
    nibs[0] = 4'h5;
    for (int i = 0; i < NN; i++) nibs[i+1] = d[23-4*i -: 4];
    nibs[NN+1] = 4'h0;
    for (int i = 0; i < NN + 2; i++) begin
      for (int b = 3; b >= 0; b--) begin
        fb  = rem[3];
        rem = {rem[2:0], nibs[i][b]};
        if (fb) rem = rem ^ 4'hD;
      end
    end
    return rem;
  endfunction

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk_rx) begin
    logic [W-1:0] e;
    if (!reset) begin
      if (sync_error)   cnt_sync++;
      if (nibble_error) cnt_nib++;
      if (timeout)      cnt_to++;
      if (frame_valid) begin
        cnt_fv++;
        check_eq("fv_alone", {sync_error, nibble_error, timeout}, 3'b000);
        check_eq("fv_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check_eq("crc_error",     crc_error,     e[32]);
          check_eq("status_nibble", status_nibble, e[31:28]);
          check_eq("frame_data",    frame_data,    e[27:4]);
          check_eq("crc_rx",        crc_rx,        e[3:0]);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_cyc(input int n);
    repeat (n) begin
      @(posedge clk_rx);
      #1;
    end
  endtask

  // One period: falling edge, low pulse, then high for the remainder.
  task automatic send_period(input int ticks);
    int lo;
    lo = (ticks > 6) ? 4 : 2;
    data_pulse = 1'b0;
    wait_cyc(lo * TD);
    data_pulse = 1'b1;
    wait_cyc((ticks - lo) * TD);
  endtask

  task automatic send_frame(input logic [3:0] st, input logic [23:0] d,
                            input logic [3:0] crc, input bit with_sync,
                            input int sync_t);
    if (with_sync) send_period(sync_t);
    send_period(int'(st) + 12);
    for (int i = 0; i < NN; i++) send_period(int'(d[23-4*i -: 4]) + 12);
    send_period(int'(crc) + 12);
  endtask

  task automatic expect_frame(input logic [3:0] st, input logic [23:0] d,
                              input logic [3:0] crc);
    exp_q.push_back({crc != ref_crc(d), st, d, crc});
    exp_fv++;
  endtask

  task automatic begin_scn();
    reset      = 1'b1;
    data_pulse = 1'b1;
    wait_cyc(3);
    reset = 1'b0;
    wait_cyc(3);
    exp_q.delete();
    cnt_fv = 0; cnt_sync = 0; cnt_nib = 0; cnt_to = 0;
    exp_fv = 0; exp_sync = 0; exp_nib = 0; exp_to = 0;
  endtask

  task automatic end_scn(input string tag);
    wait_cyc(4);
    check_eq({tag, "_fv_count"},   cnt_fv,   exp_fv);
    check_eq({tag, "_sync_err"},   cnt_sync, exp_sync);
    check_eq({tag, "_nib_err"},    cnt_nib,  exp_nib);
    check_eq({tag, "_timeout"},    cnt_to,   exp_to);
    check_eq({tag, "_exp_left"},   exp_q.size(), 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [3:0]  st, crc;
    logic [23:0] d;
    int          k, bad_t, sync_t;

    reset      = 1'b1;
    data_pulse = 1'b1;
    wait_cyc(2);
    check_eq("reset_outs",
             {frame_valid, status_nibble, frame_data, crc_rx, crc_error,
              sync_error, nibble_error, timeout}, 0);
    check_eq("reset_state", dbg_state, ST_HUNT);

    // all-zero frame with the correct CRC 5
    begin_scn();
    expect_frame(4'h0, 24'h000000, 4'h5);
    send_frame(4'h0, 24'h000000, 4'h5, 1, 56);
    send_period(20);
    end_scn("zero_frame");

    // same frame, CRC nibble 4 -> crc_error
    begin_scn();
    expect_frame(4'h0, 24'h000000, 4'h4);
    send_frame(4'h0, 24'h000000, 4'h4, 1, 56);
    send_period(20);
    end_scn("bad_crc");

    // 30-tick data nibble aborts the frame; next frame decodes
    begin_scn();
    send_period(56); send_period(12 + 3); send_period(12 + 7); send_period(30);
    exp_nib = 1;
    expect_frame(4'hA, 24'hF0F0F0, ref_crc(24'hF0F0F0));
    send_frame(4'hA, 24'hF0F0F0, ref_crc(24'hF0F0F0), 1, 56);
    send_period(20);
    end_scn("nib_30");

    // back-to-back frames with a 100-tick pause
    begin_scn();
    expect_frame(4'h3, 24'h123456, ref_crc(24'h123456));
    send_frame(4'h3, 24'h123456, ref_crc(24'h123456), 1, 56);
    send_period(100);
    expect_frame(4'hC, 24'hFEDCBA, ref_crc(24'hFEDCBA));
    send_frame(4'hC, 24'hFEDCBA, ref_crc(24'hFEDCBA), 1, 56);
    check_eq("hold_data", frame_data, 24'h123456);
    send_period(20);
    end_scn("b2b_pause");

    // 60-tick sync: error, remain in SYNC, then normal decode
    begin_scn();
    send_period(100);          // first period after HUNT: silent
    send_period(60);
    data_pulse = 1'b0;         // edge closing the 60-tick period
    wait_cyc(4 * TD);
    check_eq("sync60_state", dbg_state, ST_SYNC);
    check_eq("sync60_err", cnt_sync, 1);
    data_pulse = 1'b1;
    wait_cyc(52 * TD);
    exp_sync = 1;
    expect_frame(4'h9, 24'h0F1E2D, ref_crc(24'h0F1E2D));
    send_frame(4'h9, 24'h0F1E2D, ref_crc(24'h0F1E2D), 0, 56);
    send_period(20);
    end_scn("sync60");

    // line held high mid-DATA -> timeout, back to HUNT
    begin_scn();
    send_period(56); send_period(15); send_period(20); send_period(25);
    send_period(1100);
    check_eq("timeout_state", dbg_state, ST_HUNT);
    exp_to = 1;
    end_scn("timeout");

    // reset mid-DATA clears published outputs
    begin_scn();
    expect_frame(4'h5, 24'hA5A5A5, ref_crc(24'hA5A5A5));
    send_frame(4'h5, 24'hA5A5A5, ref_crc(24'hA5A5A5), 1, 56);
    send_period(56); send_period(13); send_period(14); send_period(15);
    data_pulse = 1'b0;
    wait_cyc(2 * TD);
    end_scn("pre_reset");
    reset = 1'b1;
    #1;
    check_eq("rst_mid_outs",
             {frame_valid, status_nibble, frame_data, crc_rx, crc_error,
              sync_error, nibble_error, timeout}, 0);
    data_pulse = 1'b1;
    wait_cyc(3);
    reset = 1'b0;
    wait_cyc(20);
    check_eq("rst_mid_after",
             {status_nibble, frame_data, crc_rx, crc_error}, 0);
    check_eq("rst_mid_no_fv", cnt_fv, exp_fv);
    check_eq("rst_mid_state", dbg_state, ST_HUNT);

    // random frames: random sync within tolerance, random pauses,
    // occasional bad CRC and occasional aborted frame
    begin_scn();
    for (int f = 0; f < 16; f++) begin
      st     = 4'($urandom_range(0, 15));
      d      = 24'($urandom);
      crc    = ref_crc(d);
      sync_t = $urandom_range(55, 57);
      if ($urandom_range(0, 3) == 0) crc = crc ^ 4'($urandom_range(1, 15));
      if ($urandom_range(0, 4) == 0) begin
        k     = $urandom_range(0, NN);
        bad_t = ($urandom_range(0, 1) == 0) ? $urandom_range(28, 45)
                                            : $urandom_range(5, 11);
        send_period(sync_t);
        send_period(int'(st) + 12);
        for (int i = 0; i < k; i++) send_period(int'(d[23-4*i -: 4]) + 12);
        send_period(bad_t);
        exp_nib++;
      end else begin
        expect_frame(st, d, crc);
        send_frame(st, d, crc, 1, sync_t);
        if ($urandom_range(0, 1) == 0)
          send_period(($urandom_range(0, 1) == 0) ? $urandom_range(12, 50)
                                                  : $urandom_range(60, 200));
      end
    end
    send_period(20);
    end_scn("random");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // watchdog: bounds the whole run
  initial begin
    #3_000_000;
    n_err++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
